// File: rtl/cpu8_pkg.sv
// cpu8_pkg: shared definitions for the 8-bit accumulator CPU instruction path.
//   INSN_W       instruction byte width; opcode in [3:0], operand in [7:4]
//   OP_*         opcode values
//   state_t      program sequencer FSM states
//   is_ctrl()    true for opcodes the sequencer consumes itself (JMP, HALT)
package cpu8_pkg;

    localparam int INSN_W = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/cpu8_prog_sequencer_if.sv
// cpu8_prog_sequencer_if: program-load port and instruction output of the
// program sequencer.
//   load_valid / load_data / load_ready : serial program load
//   insn_out / insn_valid               : instruction bytes to the CPU stage
// Modports: slave = sequencer side, master = loader / CPU-stage side.
//
// Handshake: a load byte transfers on a rising clk edge where load_valid and
// load_ready are both high and the sequencer's ena is high; load_valid and
// load_data must hold until that edge. insn_valid has no back-pressure: the
// CPU stage takes insn_out on every enabled edge where insn_valid is high.
interface cpu8_prog_sequencer_if;
    import cpu8_pkg::*;

    logic              load_valid;
    logic [INSN_W-1:0] load_data;
    logic              load_ready;
    logic [INSN_W-1:0] insn_out;
    logic              insn_valid;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  insn_out,
        input  insn_valid
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output insn_out,
        output insn_valid
    );

endinterface

// File: rtl/cpu8_prog_mem.sv
// cpu8_prog_mem: DEPTH x 8 program store; synchronous write, asynchronous read.
// Contents are not reset.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write byte
//   raddr  read address
//   rdata  read byte (combinational)
module cpu8_prog_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu8_prog_sequencer.sv
// cpu8_prog_sequencer: stores a short program loaded over a valid/ready port
// and replays it, one byte per enabled cycle, to the CPU stage. JMP and HALT
// are executed here; every other byte is forwarded unchanged.
//   clk, rst_n  clock, asynchronous active-low reset
//   ena         global enable; all state and outputs hold while low
//   clr         empty the program (IDLE/DONE only)
//   start       run from pc 0 (IDLE/DONE)
//   stop        abort RUN, back to IDLE
//   bus         load port and instruction output (slave modport)
//   pc          current fetch address
//   busy, done  state == RUN, state == DONE
//   err         sticky: illegal jump target or loop limit
//   fsm_state   raw FSM state for observation
// Build option: define CPU8_SEQ_LOOP_LIMIT_EN to add an 8-bit fetch counter
// that forces DONE with err once 255 fetches have been made in one run.
module cpu8_prog_sequencer
    import cpu8_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    clr,
    input  logic                    start,
    input  logic                    stop,
    cpu8_prog_sequencer_if.slave    bus,
    output logic [ADDR_W-1:0]       pc,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output state_t                  fsm_state
);

    // len needs one extra bit so a full memory (len == DEPTH) is representable.
    localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [INSN_W-1:0]   out_q, out_d;
    logic                vld_q, vld_d;
    logic                err_q, err_d;
    logic                mem_we;
    logic                load_ready;
    logic                limit_hit;
    logic [INSN_W-1:0]   fetch;
    logic [3:0]          op;
    logic [3:0]          tgt;
    logic                last;

`ifdef CPU8_SEQ_LOOP_LIMIT_EN
    logic [7:0] cnt_q, cnt_d;
    assign limit_hit = (cnt_q == 8'hFF);
`else
    assign limit_hit = 1'b0;
`endif

    cpu8_prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we && ena),
        .waddr (wptr_q),
        .wdata (bus.load_data),
        .raddr (pc_q),
        .rdata (fetch)
    );

    assign op         = fetch[3:0];
    assign tgt        = fetch[7:4];
    assign last       = ({1'b0, pc_q} == (len_q - LEN_ONE));
    assign load_ready = (state_q == IDLE) && (len_q < LEN_MAX);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wptr_d  = wptr_q;
        len_d   = len_q;
        out_d   = out_q;
        vld_d   = vld_q;
        err_d   = err_q;
        mem_we  = 1'b0;
`ifdef CPU8_SEQ_LOOP_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                out_d = '0;
                vld_d = 1'b0;
                if (clr) begin
                    wptr_d = '0;
                    len_d  = '0;
                    err_d  = 1'b0;
                end else begin
                    if (bus.load_valid && load_ready) begin
                        mem_we = 1'b1;
                        wptr_d = wptr_q + PTR_ONE;
                        len_d  = len_q + LEN_ONE;
                    end
                    // len_d already counts a byte accepted on this same edge.
                    if (start) begin
                        err_d   = 1'b0;
                        pc_d    = '0;
                        state_d = (len_d == '0) ? DONE : RUN;
`ifdef CPU8_SEQ_LOOP_LIMIT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    out_d   = '0;
                    vld_d   = 1'b0;
                    pc_d    = '0;
                end else if (limit_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    out_d   = '0;
                    vld_d   = 1'b0;
                end else begin
`ifdef CPU8_SEQ_LOOP_LIMIT_EN
                    cnt_d = cnt_q + 8'd1;
`endif
                    if (op == OP_JMP) begin
                        out_d = '0;
                        vld_d = 1'b0;
                        if (int'(tgt) < int'(len_q)) begin
                            pc_d = tgt[ADDR_W-1:0];
                        end else begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end
                    end else if (op == OP_HALT) begin
                        out_d   = '0;
                        vld_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        out_d = fetch;
                        vld_d = 1'b1;
                        if (last) begin
                            state_d = DONE;
                        end else begin
                            pc_d = pc_q + PTR_ONE;
                        end
                    end
                end
            end
            DONE: begin
                out_d = '0;
                vld_d = 1'b0;
                if (clr) begin
                    state_d = IDLE;
                    wptr_d  = '0;
                    len_d   = '0;
                    err_d   = 1'b0;
                    pc_d    = '0;
                end else if (stop) begin
                    state_d = IDLE;
                    pc_d    = '0;
                end else if (start) begin
                    err_d   = 1'b0;
                    pc_d    = '0;
                    state_d = (len_q == '0) ? DONE : RUN;
`ifdef CPU8_SEQ_LOOP_LIMIT_EN
                    cnt_d   = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            wptr_q  <= '0;
            len_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

`ifdef CPU8_SEQ_LOOP_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ena) begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.load_ready = load_ready;
    assign bus.insn_out   = out_q;
    assign bus.insn_valid = vld_q;
    assign pc             = pc_q;
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign err            = err_q;
    assign fsm_state      = state_q;

endmodule

// File: tb/tb_cpu8_prog_sequencer.sv
// tb_cpu8_prog_sequencer: directed and randomized checks of the program
// sequencer against a program interpreter kept in the bench.
module tb_cpu8_prog_sequencer;
    import cpu8_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        clr;
    logic        start;
    logic        stop;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        err;
    state_t      fsm_state;

    cpu8_prog_sequencer_if bus ();

    cpu8_prog_sequencer #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .clr       (clr),
        .start     (start),
        .stop      (stop),
        .bus       (bus),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic        exp_err;
    logic [7:0]  prog [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Interpreter of the program semantics: fills exp_q with the bytes the CPU
    // stage should receive and exp_err with the expected final error flag.
    task automatic interp(input int n);
        int p;
        int steps;
        logic [7:0] b;
        exp_q.delete();
        exp_err = 1'b0;
        p = 0;
        steps = 0;
        while (n > 0 && steps < 200) begin
            steps++;
            b = prog[p];
            if (b[3:0] == 4'h6) begin
                if (int'(b[7:4]) < n) p = int'(b[7:4]);
                else begin exp_err = 1'b1; break; end
            end else if (b[3:0] == 4'h7) begin
                break;
            end else begin
                exp_q.push_back(b);
                if (p == n - 1) break;
                p++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_prog(input int n, input bit gaps);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) tick();
            end
            check("load_ready_before_load", bus.load_ready, 1);
            bus.load_valid = 1'b1;
            bus.load_data  = prog[i];
            tick();
            bus.load_valid = 1'b0;
        end
    endtask

    task automatic run_and_score(input int n, input bit rand_ena);
        bit fin;
        interp(n);
        fin = 1'b0;
        ena = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared_by_start", err, 0);
        for (int c = 0; c < 300 && !fin; c++) begin
            ena = rand_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            if (ena) begin
                if (bus.insn_valid) begin
                    if (exp_q.size() == 0) check("extra_insn", bus.insn_valid, 0);
                    else check("insn_out", bus.insn_out, exp_q.pop_front());
                end
                if (done) fin = 1'b1;
            end
        end
        ena = 1'b1;
        check("run_finished", fin, 1);
        check("missing_insn", exp_q.size(), 0);
        check("err_at_end", err, exp_err);
        tick();
        check("done_out_zero", {bus.insn_valid, bus.insn_out}, 0);
        check("done_flag", done, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [7:0] b;
        logic [7:0] held;
        rst_n = 1'b0; ena = 1'b0; clr = 1'b0; start = 1'b0; stop = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = '0;
        #12;
        check("rst_insn_out", bus.insn_out, 0);
        check("rst_insn_valid", bus.insn_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_state", fsm_state, IDLE);
        check("rst_load_ready", bus.load_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;

        // Empty program: start goes straight to DONE.
        start = 1'b1; tick(); start = 1'b0;
        check("empty_start_done", done, 1);
        check("empty_start_busy", busy, 0);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_from_done_idle", fsm_state, IDLE);

        // clr wins over a same-cycle load: program stays empty.
        prog[0] = 8'h31;
        load_prog(1, 0);
        clr = 1'b1; bus.load_valid = 1'b1; bus.load_data = 8'h42;
        tick();
        clr = 1'b0; bus.load_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("clr_priority_empty", done, 1);
        clr = 1'b1; tick(); clr = 1'b0;

        // ADD 3, SUB 2: cycle-exact timing.
        prog[0] = 8'h31; prog[1] = 8'h22;
        load_prog(2, 0);
        start = 1'b1; tick(); start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_valid_k", bus.insn_valid, 0);
        check("t1_pc_k", pc, 0);
        tick();
        check("t1_first", {bus.insn_valid, bus.insn_out}, 9'h131);
        check("t1_pc1", pc, 1);
        tick();
        check("t1_second", {bus.insn_valid, bus.insn_out}, 9'h122);
        tick();
        check("t1_end_out", {bus.insn_valid, bus.insn_out}, 9'h000);
        check("t1_end_done", done, 1);
        check("t1_end_pc_hold", pc, 1);
        check("t1_done_load_ready", bus.load_ready, 0);

        // Fill all 16 entries, then offer a 17th byte.
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            if (b[3:0] == 4'h6 || b[3:0] == 4'h7) b[3:0] = 4'h1;
            prog[i] = b;
        end
        load_prog(16, 1);
        check("full_load_ready", bus.load_ready, 0);
        bus.load_valid = 1'b1; bus.load_data = 8'h77;
        tick();
        bus.load_valid = 1'b0;
        check("full_still_not_ready", bus.load_ready, 0);
        run_and_score(16, 1);

        // JMP-to-start loop.
        prog[0] = 8'h11; prog[1] = 8'h06;
        load_prog(2, 0);
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c % 2 == 0) begin
                check("loop_emit", {bus.insn_valid, bus.insn_out}, 9'h111);
                check("loop_pc_after_emit", pc, 1);
            end else begin
                check("loop_jmp_nop", {bus.insn_valid, bus.insn_out}, 9'h000);
                check("loop_pc_after_jmp", pc, 0);
            end
        end
`ifdef CPU8_SEQ_LOOP_LIMIT_EN
        n = 6;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check("loop_limit_edges", n, 256);
        check("loop_limit_err", err, 1);
`else
        stop = 1'b1; tick(); stop = 1'b0;
        check("loop_stop_state", fsm_state, IDLE);
        check("loop_stop_out", {bus.insn_valid, bus.insn_out}, 9'h000);
        check("loop_stop_pc", pc, 0);
        check("loop_stop_busy", busy, 0);
`endif

        // HALT in the middle.
        prog[0] = 8'h11; prog[1] = 8'h57; prog[2] = 8'h41;
        load_prog(3, 0);
        run_and_score(3, 0);

        // JMP 9 in a 3-byte program, then rerun.
        prog[0] = 8'h21; prog[1] = 8'h96; prog[2] = 8'h33;
        load_prog(3, 0);
        run_and_score(3, 0);
        check("bad_jmp_err", err, 1);
        run_and_score(3, 1);

        // ena low mid-run, then async reset mid-run.
        for (int i = 0; i < 6; i++) prog[i] = 8'(8'h10 * (i + 1) + 1);
        load_prog(6, 0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        held = bus.insn_out;
        check("ena_first_byte", held, 8'h11);
        ena = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("ena_low_out_frozen", bus.insn_out, 8'h11);
            check("ena_low_pc_frozen", pc, 1);
        end
        ena = 1'b1;
        tick();
        check("ena_resume_byte", bus.insn_out, 8'h21);
        check("ena_resume_pc", pc, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_out", {bus.insn_valid, bus.insn_out}, 9'h000);
        check("async_rst_pc", pc, 0);
        check("async_rst_state", fsm_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // Random programs: forward-only jumps, some out of range.
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                if (b[3:0] == 4'h6) begin
                    if (i == 15) b[3:0] = 4'h0;
                    else b[7:4] = 4'($urandom_range(i + 1, 15));
                end
                prog[i] = b;
            end
            load_prog(n, 1);
            run_and_score(n, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
